// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: raw TMDS symbol in, decoded channel and alignment status out
interface tmds_channel_decoder_if;
   logic [9:0] raw_in;
   logic [7:0] data_out;
   logic [1:0] ctrl_out;
   logic       de_out;
   logic       locked;
   logic [3:0] offset;
   modport master (output raw_in, input data_out, ctrl_out, de_out, locked, offset);
   modport slave (input raw_in, output data_out, ctrl_out, de_out, locked, offset);
endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: bit-slip word alignment on repeated control tokens, then TMDS symbol decode
module tmds_channel_decoder #(
   parameter int SLIP_WAIT   = 1023,
   parameter int LOCK_TOKENS = 8,
   parameter int LOSS_WAIT   = 4095
) (
   input logic clk_pixel,
   input logic reset_n,
   tmds_channel_decoder_if.slave bus
);
   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
   state_t      state_q, state_d;
   logic [19:0] hist_q, hist_d;
   logic [3:0]  offset_q, offset_d;
   logic [3:0]  tok_cnt_q, tok_cnt_d;
   logic [11:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [1:0]  ctrl_out_q, ctrl_out_d;
   logic        de_out_q, de_out_d;
   logic        locked_q, locked_d;
   logic [9:0]  win;
   logic [7:0]  d, dec;
   logic [1:0]  tok_val;
   logic [3:0]  slip;
   logic [11:0] idle_inc;
   logic        is_tok;
   always_comb begin
      hist_d   = {bus.raw_in, hist_q[19:10]};
      win      = hist_q[offset_q +: 10];
      is_tok   = win inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
      tok_val  = (win == 10'b0010101011) ? 2'b01 :
                 (win == 10'b0101010100) ? 2'b10 :
                 (win == 10'b1010101011) ? 2'b11 : 2'b00;
      d        = win[9] ? ~win[7:0] : win[7:0];
      dec      = {win[8] ? d[7:1] ^ d[6:0] : ~(d[7:1] ^ d[6:0]), d[0]};
      slip     = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      idle_inc = idle_cnt_q + 12'd1;
   end
   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      tok_cnt_d  = tok_cnt_q;
      idle_cnt_d = idle_cnt_q;
      case (state_q)
         SEARCH:
            if (is_tok) begin
               state_d    = CHECK;
               tok_cnt_d  = 4'd1;
               idle_cnt_d = 12'd0;
            end else if (idle_inc == 12'(SLIP_WAIT)) begin
               offset_d   = slip;
               idle_cnt_d = 12'd0;
            end else
               idle_cnt_d = idle_inc;
         CHECK:
            if (is_tok) begin
               tok_cnt_d = tok_cnt_q + 4'd1;
               if (tok_cnt_d == 4'(LOCK_TOKENS)) state_d = LOCKED;
            end else begin
               state_d    = SEARCH;
               offset_d   = slip;
               tok_cnt_d  = 4'd0;
               idle_cnt_d = 12'd0;
            end
         LOCKED:
            if (is_tok)
               idle_cnt_d = 12'd0;
            else if (idle_inc == 12'(LOSS_WAIT)) begin
               state_d    = SEARCH;
               idle_cnt_d = 12'd0;
            end else
               idle_cnt_d = idle_inc;
         default: state_d = SEARCH;
      endcase
      // outputs follow the next state so lock and loss show on the deciding edge
      locked_d   = state_d == LOCKED;
      de_out_d   = locked_d && !is_tok;
      ctrl_out_d = !locked_d ? 2'b00 : is_tok ? tok_val : ctrl_out_q;
      data_out_d = !locked_d ? 8'h00 : is_tok ? data_out_q : dec;
   end
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state_q    <= SEARCH;
         hist_q     <= '0;
         offset_q   <= '0;
         tok_cnt_q  <= '0;
         idle_cnt_q <= '0;
         data_out_q <= '0;
         ctrl_out_q <= '0;
         de_out_q   <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         offset_q   <= offset_d;
         tok_cnt_q  <= tok_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         data_out_q <= data_out_d;
         ctrl_out_q <= ctrl_out_d;
         de_out_q   <= de_out_d;
         locked_q   <= locked_d;
      end
   end
   assign bus.data_out = data_out_q;
   assign bus.ctrl_out = ctrl_out_q;
   assign bus.de_out   = de_out_q;
   assign bus.locked   = locked_q;
   assign bus.offset   = offset_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: DVI-encoded symbol streams serialised with a bit delay, checked against transmitted values
module tb_tmds_channel_decoder;
   logic clk_pixel = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_pixel = ~clk_pixel;
   tmds_channel_decoder_if a_if();
   tmds_channel_decoder_if b_if();
   tmds_channel_decoder #(.SLIP_WAIT(15), .LOCK_TOKENS(8), .LOSS_WAIT(4095)) dut_a (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .bus(a_if.slave));
   tmds_channel_decoder #(.SLIP_WAIT(15), .LOCK_TOKENS(8), .LOSS_WAIT(100)) dut_b (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .bus(b_if.slave));
   int tests = 0;
   int fails = 0;
   int disp = 0;
   logic [9:0] syms[$];
   bit         is_t[$];
   logic [7:0] vals[$];
   logic [9:0] tok_v [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic [9:0] w);
      a_if.raw_in = w;
      b_if.raw_in = w;
      @(posedge clk_pixel);
      #1;
   endtask
   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) drive(10'd0);
      reset_n = 1'b1;
      disp = 0;
      syms.delete();
      is_t.delete();
      vals.delete();
   endtask
   // standard DVI encoder with running disparity
   task automatic push_byte(input logic [7:0] b);
      int n1, n1q;
      logic [8:0] qm;
      logic [9:0] q;
      n1 = $countones(b);
      qm[0] = b[0];
      if (n1 > 4 || (n1 == 4 && !b[0])) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      if (disp == 0 || n1q == 4) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         disp += qm[8] ? (2 * n1q - 8) : (8 - 2 * n1q);
      end else if ((disp > 0 && n1q > 4) || (disp < 0 && n1q < 4)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         disp += 2 * int'(qm[8]) + 8 - 2 * n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         disp += -2 * int'(!qm[8]) + 2 * n1q - 8;
      end
      syms.push_back(q);
      is_t.push_back(1'b0);
      vals.push_back(b);
   endtask
   task automatic push_tok(input int c);
      syms.push_back(tok_v[c]);
      is_t.push_back(1'b1);
      vals.push_back(8'(c));
   endtask
   // serialise symbols LSB first after `delay` random bits; output after word w reflects symbol w-2
   task automatic play(input int delay, input int chk_from, input int lock_at, input int loss_at);
      bit bits[$];
      int nw, s;
      logic [9:0] w10;
      for (int i = 0; i < delay; i++) bits.push_back(1'($urandom));
      foreach (syms[k]) for (int b = 0; b < 10; b++) bits.push_back(syms[k][b]);
      nw = (bits.size() + 9) / 10 + 2;
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 10; b++) w10[b] = (10 * w + b < bits.size()) ? bits[10 * w + b] : 1'b0;
         drive(w10);
         s = w - 2;
         if (w >= chk_from && s >= 0 && s < syms.size()) begin
            chk("stream_locked", a_if.locked, 1);
            chk("stream_offset", a_if.offset, delay);
            chk("stream_de", a_if.de_out, !is_t[s]);
            if (is_t[s]) chk("stream_ctrl", a_if.ctrl_out, vals[s][1:0]);
            else chk("stream_data", a_if.data_out, vals[s]);
         end
         if (w == lock_at - 1) chk("pre_lock", a_if.locked, 0);
         if (w == lock_at) begin
            chk("lock_edge", a_if.locked, 1);
            chk("lock_de", a_if.de_out, 0);
            chk("lock_ctrl", a_if.ctrl_out, vals[7][1:0]);
            chk("lock_data", a_if.data_out, 0);
         end
         if (w == loss_at - 1) begin
            chk("pre_loss_locked", b_if.locked, 1);
            chk("pre_loss_de", b_if.de_out, 1);
         end
         if (w == loss_at) begin
            chk("loss_locked", b_if.locked, 0);
            chk("loss_de", b_if.de_out, 0);
            chk("loss_offset", b_if.offset, 0);
         end
      end
   endtask
   initial begin
      int perm [256];
      a_if.raw_in = '0;
      b_if.raw_in = '0;
      reset_n = 1'b0;
      repeat (4) begin
         drive(10'($urandom));
         chk("rst_data", a_if.data_out, 0);
         chk("rst_ctrl", a_if.ctrl_out, 0);
         chk("rst_de", a_if.de_out, 0);
         chk("rst_locked", a_if.locked | b_if.locked, 0);
         chk("rst_offset", a_if.offset, 0);
      end
      reset_n = 1'b1;
      repeat (10) begin
         drive(10'd0);
         chk("post_rst_locked", a_if.locked, 0);
      end
      do_reset();
      for (int i = 0; i < 160; i++) push_tok(0);
      for (int i = 0; i < 640; i++) push_byte(8'hFF);
      play(0, 9, 9, -1);
      do_reset();
      for (int i = 0; i < 20; i++) push_tok(0);
      for (int i = 0; i < 150; i++) push_byte(8'h10);
      play(0, 9, 9, 121);
      do_reset();
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 16; i++) push_tok(i % 4);
      for (int i = 0; i < 256; i++) begin
         if (i % 16 == 0) for (int c = 0; c < 4; c++) push_tok((c + i / 16) % 4);
         push_byte(8'(perm[i]));
      end
      play(0, 9, 9, -1);
      reset_n = 1'b0;
      drive(10'd0);
      chk("mid_lock_rst_a", a_if.locked, 0);
      chk("mid_lock_rst_b", b_if.locked, 0);
      do_reset();
      drive(tok_v[1]);
      drive(10'd0);
      drive(10'd0);
      chk("false_tok_check_offset", a_if.offset, 0);
      drive(10'd0);
      chk("false_tok_offset", a_if.offset, 1);
      chk("false_tok_locked", a_if.locked, 0);
      do_reset();
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 160; i++) push_tok(0);
         for (int i = 0; i < 640; i++) push_byte(8'($urandom));
      end
      play(3, 1602, -1, -1);
      chk("misalign_locked", a_if.locked, 1);
      chk("misalign_offset", a_if.offset, 3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
